// File: rtl/mem_load_unit_pkg.sv
// Shared constants for the memory-stage load unit: memop encoding and FSM states.
package mem_load_unit_pkg;

    // Width of the one-hot memop bus
    localparam int unsigned MMOP = 12;

    // One-hot memop codes; bit position identifies the operation
    localparam logic [MMOP-1:0] OpLb  = 12'h001;
    localparam logic [MMOP-1:0] OpLbu = 12'h002;
    localparam logic [MMOP-1:0] OpLh  = 12'h004;
    localparam logic [MMOP-1:0] OpLhu = 12'h008;
    localparam logic [MMOP-1:0] OpLw  = 12'h010;
    localparam logic [MMOP-1:0] OpSb  = 12'h020;
    localparam logic [MMOP-1:0] OpSh  = 12'h040;
    localparam logic [MMOP-1:0] OpSw  = 12'h080;
    localparam logic [MMOP-1:0] OpLwl = 12'h100;
    localparam logic [MMOP-1:0] OpLwr = 12'h200;
    localparam logic [MMOP-1:0] OpSwl = 12'h400;
    localparam logic [MMOP-1:0] OpSwr = 12'h800;

    localparam logic [MMOP-1:0] LoadMask = OpLb | OpLbu | OpLh | OpLhu | OpLw | OpLwl | OpLwr;

    // Transaction tracking states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StBuf   = 2'd2,
        StDrain = 2'd3
    } state_e;

    // True when the memop produces its result from returned data
    function automatic logic is_load(input logic [MMOP-1:0] memop);
        return |(memop & LoadMask);
    endfunction

endpackage

// File: rtl/mem_load_unit_load_align.sv
// Combinational load extraction: selects, extends and merges returned data.
module load_align
    import mem_load_unit_pkg::*;
(
    input  logic [MMOP-1:0] memop,
    input  logic [1:0]      addr_low,
    input  logic [31:0]     rdata,
    input  logic [31:0]     rt,
    output logic [31:0]     result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;

    // Little-endian byte/half pick and unaligned-word merges
    always_comb begin
        byte_sel = 8'h00;
        lwl_val  = 32'h0;
        lwr_val  = 32'h0;
        half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];
        unique case (addr_low)
            2'd0: begin
                byte_sel = rdata[7:0];
                lwl_val  = {rdata[7:0], rt[23:0]};
                lwr_val  = rdata;
            end
            2'd1: begin
                byte_sel = rdata[15:8];
                lwl_val  = {rdata[15:0], rt[15:0]};
                lwr_val  = {rt[31:24], rdata[31:8]};
            end
            2'd2: begin
                byte_sel = rdata[23:16];
                lwl_val  = {rdata[23:0], rt[7:0]};
                lwr_val  = {rt[31:16], rdata[31:16]};
            end
            2'd3: begin
                byte_sel = rdata[31:24];
                lwl_val  = rdata;
                lwr_val  = {rt[31:8], rdata[31:24]};
            end
        endcase
    end

    // Result select by memop; non-loads yield zero and are replaced upstream
    always_comb begin
        result = 32'h0;
        unique case (memop)
            OpLb:    result = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   result = {24'h0, byte_sel};
            OpLh:    result = {{16{half_sel[15]}}, half_sel};
            OpLhu:   result = {16'h0, half_sel};
            OpLw:    result = rdata;
            OpLwl:   result = lwl_val;
            OpLwr:   result = lwr_val;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Memory-stage load unit: tracks the single outstanding data transaction,
// stalls until data_ok, buffers data under downstream stall, drains flushed
// responses and forms the stage result.
module mem_load_unit
    import mem_load_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_flush_i,
    input  logic            mem_stall_i,
    input  logic            mem_memen_i,
    input  logic [MMOP-1:0] mem_memop_i,
    input  logic [1:0]      mem_memaddr_low_i,
    input  logic [31:0]     mem_alures_i,
    input  logic [31:0]     mem_rtvalue_i,
    input  logic            data_ok,
    input  logic [31:0]     data_rdata,
    output logic [31:0]     mem_wdata_o,
    output logic            mem_stallreq_o,
    output logic            mem_busy_o
);

    state_e      state_q, state_d;
    logic [31:0] buf_q;
    logic        buf_we;
    logic [31:0] align_src;
    logic [31:0] align_res;
    logic        use_load;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Data buffer, loaded only when data returns while downstream is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= 32'h0;
        end else if (buf_we) begin
            buf_q <= data_rdata;
        end
    end

    // Next state, buffer enable and handshake outputs; flush beats stall
    always_comb begin
        state_d        = state_q;
        buf_we         = 1'b0;
        mem_stallreq_o = 1'b0;
        mem_busy_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_memen_i) begin
                    if (data_ok) begin
                        if (!mem_flush_i && mem_stall_i) begin
                            state_d = StBuf;
                            buf_we  = 1'b1;
                        end
                    end else begin
                        mem_stallreq_o = 1'b1;
                        mem_busy_o     = 1'b1;
                        state_d        = mem_flush_i ? StDrain : StWait;
                    end
                end
            end
            StWait: begin
                mem_busy_o = 1'b1;
                if (data_ok) begin
                    if (mem_flush_i) begin
                        state_d = StIdle;
                    end else if (mem_stall_i) begin
                        state_d = StBuf;
                        buf_we  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    mem_stallreq_o = 1'b1;
                    if (mem_flush_i) begin
                        state_d = StDrain;
                    end
                end
            end
            StBuf: begin
                if (mem_flush_i || !mem_stall_i) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // Owed response belongs to a flushed instruction; swallow it
                mem_busy_o = 1'b1;
                if (data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage result: aligned load data from bus or buffer, else the ALU result
    always_comb begin
        align_src   = (state_q == StBuf) ? buf_q : data_rdata;
        use_load    = mem_memen_i && is_load(mem_memop_i) && (state_q != StDrain);
        mem_wdata_o = use_load ? align_res : mem_alures_i;
    end

    load_align u_load_align (
        .memop    (mem_memop_i),
        .addr_low (mem_memaddr_low_i),
        .rdata    (align_src),
        .rt       (mem_rtvalue_i),
        .result   (align_res)
    );

    // A response with nothing outstanding breaks the bus protocol
    a_no_orphan_data_ok : assert property (
        @(posedge clk) disable iff (!rst_n)
        !((state_q == StIdle) && !mem_memen_i && data_ok)
    );

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit: directed scenarios then random
// transactions checked against a transaction-level reference model.
module tb_mem_load_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        memen;
    logic [11:0] memop;
    logic [1:0]  addr_low;
    logic [31:0] alures;
    logic [31:0] rt_value;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        stallreq;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_load_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_flush_i       (flush),
        .mem_stall_i       (stall),
        .mem_memen_i       (memen),
        .mem_memop_i       (memop),
        .mem_memaddr_low_i (addr_low),
        .mem_alures_i      (alures),
        .mem_rtvalue_i     (rt_value),
        .data_ok           (data_ok),
        .data_rdata        (rdata),
        .mem_wdata_o       (wdata),
        .mem_stallreq_o    (stallreq),
        .mem_busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: expected stage result from memop index and operands
    function automatic logic [31:0] ref_result(input int op, input logic [1:0] a,
                                               input logic [31:0] rd, input logic [31:0] rt,
                                               input logic [31:0] alu);
        int          sh;
        int          hs;
        logic [31:0] b;
        logic [31:0] h;
        sh = 8 * int'(a);
        hs = a[1] ? 16 : 0;
        b  = (rd >> sh) & 32'hFF;
        h  = (rd >> hs) & 32'hFFFF;
        case (op)
            0:       return b[7] ? (b | 32'hFFFF_FF00) : b;
            1:       return b;
            2:       return h[15] ? (h | 32'hFFFF_0000) : h;
            3:       return h;
            4:       return rd;
            8:       return (rd << (24 - sh)) | (rt & ((32'h1 << (24 - sh)) - 32'h1));
            9:       return (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: return alu;
        endcase
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, settle, then return
    task automatic drive(input logic me, input int op, input logic [1:0] a,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic dok, input logic [31:0] rd,
                         input logic st, input logic fl);
        @(negedge clk);
        memen    = me;
        memop    = me ? (12'h001 << op) : 12'h000;
        addr_low = a;
        alures   = alu;
        rt_value = rt;
        data_ok  = dok;
        rdata    = rd;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    task automatic idle_step(input string tag);
        logic [31:0] alu;
        alu = $urandom;
        drive(1'b0, 0, 2'd0, alu, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
        chk1({tag, "_stallreq"}, stallreq, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk32({tag, "_result"}, wdata, alu);
    endtask

    // One transaction: dly cycles without data, then data_ok with stall held
    // for nst cycles (counting the data cycle), then an idle cycle
    task automatic txn(input int op, input logic [1:0] a, input logic [31:0] rt,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input int dly, input int nst, input logic [31:0] exp);
        for (int c = 0; c < dly; c++) begin
            drive(1'b1, op, a, alu, rt, 1'b0, $urandom, 1'b0, 1'b0);
            chk1("wait_stallreq", stallreq, 1'b1);
            chk1("wait_busy", busy, 1'b1);
        end
        drive(1'b1, op, a, alu, rt, 1'b1, rd, nst > 0, 1'b0);
        chk32("dok_result", wdata, exp);
        chk1("dok_stallreq", stallreq, 1'b0);
        for (int k = 1; k <= nst; k++) begin
            drive(1'b1, op, a, alu, rt, 1'b0, $urandom, k < nst, 1'b0);
            chk32("buf_result", wdata, exp);
            chk1("buf_stallreq", stallreq, 1'b0);
            chk1("buf_busy", busy, 1'b0);
        end
        idle_step("post_txn");
    endtask

    // Flush after f waiting cycles; response arrives g cycles later and is dropped
    task automatic flush_txn(input int op, input logic [1:0] a, input logic [31:0] rt,
                             input logic [31:0] alu, input int f, input int g);
        logic [31:0] alu2;
        for (int c = 0; c < f; c++) begin
            drive(1'b1, op, a, alu, rt, 1'b0, $urandom, 1'b0, 1'b0);
            chk1("fl_wait_stallreq", stallreq, 1'b1);
        end
        drive(1'b1, op, a, alu, rt, 1'b0, $urandom, 1'b1, 1'b1);
        chk1("fl_busy", busy, 1'b1);
        for (int c = 0; c < g; c++) begin
            alu2 = $urandom;
            drive(1'b0, 0, 2'd0, alu2, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
            chk1("drain_stallreq", stallreq, 1'b0);
            chk1("drain_busy", busy, 1'b1);
            chk32("drain_result", wdata, alu2);
        end
        alu2 = $urandom;
        drive(1'b0, 0, 2'd0, alu2, $urandom, 1'b1, $urandom, 1'b0, 1'b0);
        chk1("drain_dok_stallreq", stallreq, 1'b0);
        chk32("drain_dok_result", wdata, alu2);
        idle_step("post_drain");
    endtask

    initial begin
        int          op;
        logic [1:0]  a;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] rd;

        rst_n    = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        memen    = 1'b0;
        memop    = 12'h000;
        addr_low = 2'd0;
        alures   = 32'h0;
        rt_value = 32'h0;
        data_ok  = 1'b0;
        rdata    = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk1("reset_stallreq", stallreq, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk32("reset_result", wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // lb, byte 2 sign-extended, zero latency
        txn(0, 2'd2, $urandom, $urandom, 32'h1280_3456, 0, 0, 32'hFFFF_FF80);
        // lhu, three stall cycles
        txn(3, 2'd2, $urandom, $urandom, 32'hBEEF_0000, 3, 0, 32'h0000_BEEF);
        // lwl / lwr merges
        txn(8, 2'd1, 32'hAABB_CCDD, $urandom, 32'h1122_3344, 0, 0, 32'h3344_CCDD);
        txn(9, 2'd1, 32'hAABB_CCDD, $urandom, 32'h1122_3344, 0, 0, 32'hAA11_2233);
        // lw captured under downstream stall, bus data changes afterward
        txn(4, 2'd0, $urandom, $urandom, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D);
        // sw with one-cycle delay yields the ALU result
        txn(7, 2'd1, $urandom, 32'h1000_0040, $urandom, 1, 0, 32'h1000_0040);
        // Flush in WAIT, response two cycles later
        flush_txn(4, 2'd0, $urandom, $urandom, 1, 1);

        // Flush coinciding with data_ok: no buffering, next load sees fresh data
        drive(1'b1, 4, 2'd0, $urandom, $urandom, 1'b1, 32'hDEAD_0001, 1'b1, 1'b1);
        txn(4, 2'd0, $urandom, $urandom, 32'h0BAD_CAFE, 0, 0, 32'h0BAD_CAFE);

        // Flush while buffered: buffer discarded
        drive(1'b1, 4, 2'd0, 32'h0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
        chk32("prebuf_result", wdata, 32'h5555_AAAA);
        drive(1'b1, 4, 2'd0, 32'h0, 32'h0, 1'b0, $urandom, 1'b1, 1'b1);
        chk32("buf_flush_result", wdata, 32'h5555_AAAA);
        txn(4, 2'd0, $urandom, $urandom, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF);

        // Reset while waiting: outputs return to reset values at once
        drive(1'b1, 4, 2'd0, $urandom, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
        drive(1'b1, 4, 2'd0, $urandom, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
        chk1("pre_rst_stallreq", stallreq, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        memen    = 1'b0;
        memop    = 12'h000;
        alures   = 32'h0;
        rt_value = 32'h0;
        rdata    = 32'h0;
        #1;
        chk1("mid_rst_stallreq", stallreq, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_result", wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step("post_rst");

        // Random transactions against the reference model
        for (int i = 0; i < 80; i++) begin
            op  = int'($urandom_range(0, 11));
            a   = 2'($urandom_range(0, 3));
            rt  = $urandom;
            alu = $urandom;
            rd  = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                flush_txn(op, a, rt, alu, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                txn(op, a, rt, alu, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    ref_result(op, a, rd, rt, alu));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
